response_judge: RTL



---
 rtl/notnot_pkg.sv | 43 ++++
 rtl/response_judge_if.sv | 27 ++
 rtl/deadline_timer.sv | 29 ++
 rtl/response_judge.sv | 112 +++++++++++
 4 files changed

// File: rtl/notnot_pkg.sv
// Shared NOT-NOT definitions: instruction codes, key bit positions, judge
// state encoding and the instruction-to-key mapping.
package notnot_pkg;

  localparam logic [2:0] INS_UP    = 3'b000;
  localparam logic [2:0] INS_DOWN  = 3'b001;
  localparam logic [2:0] INS_LEFT  = 3'b010;
  localparam logic [2:0] INS_RIGHT = 3'b011;
  localparam logic [2:0] INS_L     = 3'b100;
  localparam logic [2:0] INS_R     = 3'b101;

  localparam int KEY_W = 0;
  localparam int KEY_A = 1;
  localparam int KEY_S = 2;
  localparam int KEY_D = 3;
  localparam int KEY_R = 4;
  localparam int KEY_L = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_RELEASE,
    ST_WAIT_PRESS,
    ST_REPORT,
    ST_OVER
  } judge_state_t;

  // The correct key is the opposite of the shown instruction; 110/111 have none.
  function automatic logic [5:0] expected_key(input logic [2:0] ins);
    logic [5:0] key;
    key = '0;
    case (ins)
      INS_UP:    key[KEY_S] = 1'b1;
      INS_DOWN:  key[KEY_W] = 1'b1;
      INS_LEFT:  key[KEY_D] = 1'b1;
      INS_RIGHT: key[KEY_A] = 1'b1;
      INS_L:     key[KEY_R] = 1'b1;
      INS_R:     key[KEY_L] = 1'b1;
      default:   key = '0;
    endcase
    return key;
  endfunction

endpackage

// File: rtl/response_judge_if.sv
// Handshake between the instruction/input side and the response judge.
interface response_judge_if #(
  parameter int SCORE_W = 8
) ();

  logic               arm;
  logic [2:0]         ins;
  logic [5:0]         user_input;
  logic               busy;
  logic               result_valid;
  logic               result_correct;
  logic               timed_out;
  logic [SCORE_W-1:0] score;
  logic [1:0]         lives;
  logic               game_over;

  modport master (
    output arm, ins, user_input,
    input  busy, result_valid, result_correct, timed_out, score, lives, game_over
  );

  modport slave (
    input  arm, ins, user_input,
    output busy, result_valid, result_correct, timed_out, score, lives, game_over
  );

endinterface

// File: rtl/deadline_timer.sv
// Cycle counter for a response window; flags the last cycle of the window
// and holds there until cleared.
module deadline_timer #(
  parameter int TIMEOUT_CYCLES = 150_000_000,
  parameter int CNT_W          = 28
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/response_judge.sv
// Registered NOT-NOT judge: one verdict per armed instruction, with a timed
// response window, saturating score, lives and a sticky game-over.
module response_judge
  import notnot_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 150_000_000,
  parameter int CNT_W          = 28,
  parameter int SCORE_W        = 8,
  parameter int LIVES_INIT     = 3
) (
  input logic             clk,
  input logic             reset,
  response_judge_if.slave bus
);

  judge_state_t       state;
  logic [2:0]         ins_q;
  logic               result_valid_q;
  logic               result_correct_q;
  logic               timed_out_q;
  logic [SCORE_W-1:0] score_q;
  logic [1:0]         lives_q;
  logic               game_over_q;

  logic busy;
  logic press;
  logic start;
  logic timer_expired;
  logic judge_now;
  logic verdict_correct;
  logic verdict_timeout;

  assign busy  = (state == ST_WAIT_RELEASE) || (state == ST_WAIT_PRESS);
  assign press = |bus.user_input;
  assign start = (state == ST_IDLE) && bus.arm && !game_over_q;

  deadline_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (start),
    .enable (busy),
    .expired(timer_expired)
  );

  // A press in WAIT_PRESS beats a timeout landing on the same cycle.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    judge_now       = 1'b0;
    verdict_correct = 1'b0;
    verdict_timeout = 1'b0;
    if (state == ST_WAIT_PRESS && press) begin
      judge_now       = 1'b1;
      verdict_correct = (bus.user_input == expected_key(ins_q));
    end else if (busy && timer_expired) begin
      judge_now       = 1'b1;
      verdict_timeout = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= ST_IDLE;
      ins_q            <= '0;
      result_valid_q   <= 1'b0;
      result_correct_q <= 1'b0;
      timed_out_q      <= 1'b0;
      score_q          <= '0;
      lives_q          <= 2'(LIVES_INIT);
      game_over_q      <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      if (judge_now) begin
        state            <= ST_REPORT;
        result_valid_q   <= 1'b1;
        result_correct_q <= verdict_correct;
        timed_out_q      <= verdict_timeout;
        if (verdict_correct) begin
          if (score_q != '1) score_q <= score_q + SCORE_W'(1);
        end else if (lives_q != 2'd0) begin
          lives_q <= lives_q - 2'd1;
          if (lives_q == 2'd1) game_over_q <= 1'b1;
        end
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (start) begin
              ins_q <= bus.ins;
              state <= press ? ST_WAIT_RELEASE : ST_WAIT_PRESS;
            end
          end
          ST_WAIT_RELEASE: if (!press) state <= ST_WAIT_PRESS;
          ST_WAIT_PRESS:   state <= ST_WAIT_PRESS;
          ST_REPORT:       state <= game_over_q ? ST_OVER : ST_IDLE;
          ST_OVER:         state <= ST_OVER;
          default:         state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.busy           = busy;
  assign bus.result_valid   = result_valid_q;
  assign bus.result_correct = result_correct_q;
  assign bus.timed_out      = timed_out_q;
  assign bus.score          = score_q;
  assign bus.lives          = lives_q;
  assign bus.game_over      = game_over_q;

endmodule
